// File: rtl/dataflow_pkg.sv
// Shared token-layout helpers for dataflow actors and the buffers between them.
// A token is {tag, data} with the tag in the MSBs.
package dataflow_pkg;

    // Number of tag bits needed to name every flux (at least one bit).
    function automatic int tag_width(input int flux);
        return (flux > 1) ? $clog2(flux) : 1;
    endfunction

    // Full token width: payload plus tag.
    function automatic int token_width(input int data_width, input int flux);
        return data_width + tag_width(flux);
    endfunction

    // Packs a tag and payload into the {tag, data} layout (caller truncates to its width).
    function automatic logic [63:0] pack_token(input logic [31:0] tag,
                                               input logic [31:0] data,
                                               input int          data_width);
        logic [63:0] mask;
        mask = (64'd1 << data_width) - 64'd1;
        return (64'(tag) << data_width) | (64'(data) & mask);
    endfunction

endpackage

// File: rtl/tagged_fifo_bank_flux_fifo.sv
// One circular FWFT FIFO of the tagged bank: pointers, occupancy counter,
// sticky overflow flag and the zero-forced head-of-queue output mux.
module flux_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_req,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_req,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [CNT_W-1:0] cnt;
    logic             ovf_q;
    logic             wr_acc;
    logic             rd_acc;

    // Status comes straight from the counter register, so a same-cycle read
    // never frees room for a same-cycle write on a full FIFO.
    assign full     = (cnt == CNT_W'(DEPTH));
    assign empty    = (cnt == '0);
    assign overflow = ovf_q;
    assign wr_acc   = wr_req & ~full;
    assign rd_acc   = rd_req & ~empty;
    assign dout     = empty ? '0 : mem[rptr];

    // Control state: pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            cnt   <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (wr_acc) wptr <= wptr + PTR_W'(1);
            if (rd_acc) rptr <= rptr + PTR_W'(1);
            unique case ({wr_acc, rd_acc})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
            if (wr_req && full) ovf_q <= 1'b1;
        end
    end

    // Storage is never cleared; only accepted writes outside reset land here.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) mem[wptr] <= din;
    end

endmodule

// File: rtl/tagged_fifo_bank.sv
// Tagged-token buffer: steers each {tag, data} word to the FIFO named by its
// tag and exposes per-flux full/empty/overflow plus FWFT read ports.
module tagged_fifo_bank
    import dataflow_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int FLUX       = 2,
    parameter  int DEPTH      = 4,
    localparam int TAG_WIDTH  = tag_width(FLUX),
    localparam int WIDTH      = token_width(DATA_WIDTH, FLUX)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write,
    input  logic [WIDTH-1:0]      din,
    output logic [FLUX-1:0]       full,
    input  logic [FLUX-1:0]       read,
    output logic [FLUX*WIDTH-1:0] dout,
    output logic [FLUX-1:0]       empty,
    output logic [FLUX-1:0]       overflow
);

    logic [TAG_WIDTH-1:0] tag;

    // Tags that name no flux match no instance, so the word is silently dropped.
    assign tag = din[WIDTH-1 -: TAG_WIDTH];

    genvar f;
    generate
        for (f = 0; f < FLUX; f++) begin : g_flux
            logic wr_req;

            assign wr_req = write && (32'(tag) == f);

            flux_fifo #(
                .WIDTH (WIDTH),
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk      (clk),
                .rst      (rst),
                .wr_req   (wr_req),
                .din      (din),
                .rd_req   (read[f]),
                .dout     (dout[f*WIDTH +: WIDTH]),
                .full     (full[f]),
                .empty    (empty[f]),
                .overflow (overflow[f])
            );
        end
    endgenerate

endmodule

// File: doc/tagged_fifo_bank.md
# tagged_fifo_bank

Tagged-token buffer that sits directly downstream of a multi-flux dataflow actor. It accepts one `{tag, data}` word per cycle on a single write port and steers it into one of FLUX independent circular FIFOs selected by the tag. It exposes a per-flux `full` vector back to the producer and per-flux first-word-fall-through read ports towards the next actor. The tag is preserved in the stored word, so consumers can chain to another actor unchanged.

## Interface
Reset is synchronous and active-high; single clock `clk`, reset `rst`.

Parameters:
- `DATA_WIDTH`, 8, payload bits per token
- `FLUX`, 2, number of independent fluxes; must be ≥2
- `DEPTH`, 4, words per flux FIFO; power of two, ≥2

Derived constants:
- `TAG_WIDTH` = $clog2(FLUX)
- `WIDTH` = DATA_WIDTH+TAG_WIDTH

Ports:
- `clk` in 1: clock, all state on rising edge
- `rst` in 1: synchronous, active-high reset
- `write` in 1: write strobe for `din`
- `din` in WIDTH: `{tag, data}`; tag in MSBs
- `full` out FLUX: `full[f]` = FIFO f holds DEPTH words
- `read` in FLUX: `read[f]` pops the head of FIFO f
- `dout` out FLUX*WIDTH: slice f = bits [f*WIDTH +: WIDTH], head word of FIFO f
- `empty` out FLUX: `empty[f]` = FIFO f holds 0 words
- `overflow` out FLUX: sticky; write attempted to full FIFO f

## Operation
- **Tag decode:** `tag = din[WIDTH-1 -: TAG_WIDTH]`. A tag ≥ FLUX is dropped and sets no flag.
- **Write accept:** `write & ~full[tag]` writes the whole `din` (tag included) at `wptr[tag]`. `wptr[tag]` increments mod DEPTH.
- **Write refused:** `write & full[tag]` leaves all state unchanged, except that `overflow[tag]` is set to 1.
- **Read accept:** `read[f] & ~empty[f]` increments `rptr[f]` mod DEPTH. A read while empty is ignored.
- **Per-flux counter:** `cnt[f]` is $clog2(DEPTH)+1 bits.
  - +1 on accepted write only.
  - −1 on accepted read only.
  - Unchanged on both or neither.
- **Status flags:** `full[f] = (cnt[f]==DEPTH)`, `empty[f] = (cnt[f]==0)`. Both decode from registers only; there is no combinational path from `read` or `write` to `full` or `empty`.
- **Simultaneous read and write on a full FIFO:** the write is still refused, because `full` is registered status. The read proceeds.
- **Concurrency:** reads on several fluxes in the same cycle are independent. At most one write per cycle.
- **`dout` slice f:**
  - When `empty[f]=0`, it is `mem[f][rptr[f]]` (combinational, first-word fall-through).
  - When `empty[f]=1`, it is forced to 0.
- **Reset:**
  - Pointers and counters clear, giving `empty` all 1 and `full` all 0.
  - `overflow` clears to 0; `dout` reads 0.
  - Memory contents are not reset.
  - `write` and `read` are ignored while `rst=1`.

## Timing
- **Write-to-read latency:** 1 cycle. A word accepted at edge N appears on `dout` with `empty[f]=0` after edge N.
- **Read:** the head is consumed at the edge where `read[f]=1`, and the next word (or 0/empty) is visible after that edge.
- **Throughput:** one write and FLUX reads per cycle, sustained.
- **Wrap-around:** pointers wrap DEPTH-1 → 0 with no bubble.
- **`overflow`:** asserts the cycle after the refused write and holds until `rst`.
- **Mid-operation reset:** `rst` asserted for one cycle discards all queued words. Outputs are at reset values on the following cycle.

## Structure
- **Shared package `dataflow_pkg`:** holds the `TAG_WIDTH`/`WIDTH` derivation functions and the token packing helper (`{tag, data}` layout). The actor and buffer stages both use it.
- **Sub-module `flux_fifo`:** one DEPTH×WIDTH circular FIFO containing wptr, rptr, cnt, overflow flag and the FWFT read mux.
- **Top level:** `tagged_fifo_bank` instantiates FLUX `flux_fifo` instances in a generate loop and drives each instance's write enable from the tag decode.

## Test plan
1. **Reset:** `rst` for 2 cycles → `empty=2'b11`, `full=2'b00`, `overflow=2'b00`, `dout=18'h0`.
2. **Single write:** write `din=9'h12A` (tag 1, data 0x2A) → next cycle `empty=2'b01`, `dout[17:9]=9'h12A`, `dout[8:0]=0`.
3. **Fill and overflow:** write 0x01..0x04 to flux 0 → `full[0]=1` after the 4th write. Fifth write 0x05 → ignored, `overflow[0]=1`. Four reads return 0x01..0x04, then `empty[0]=1`.
4. **Wrap-around:** write 3, read 3, write 4 words 0xA0..0xA3 to flux 1 → reads return 0xA0..0xA3 in order, and `full[1]=1` after the 4th write.
5. **Simultaneous access:** flux 0 holds 2 words; assert `read[0]` plus a write of tag 0 for 3 cycles → count stays 2 and FIFO order is preserved. With flux 0 full, the same stimulus → the write is refused, the read is accepted, and `overflow[0]=1`.
6. **Reset mid-operation:** flux 1 holds 3 words; assert `rst` for one cycle with `write` of tag 1 active → next cycle `empty[1]=1`, nothing stored, `overflow=0`.
